lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between the execute stage and the data-memory block.
//  Accepts one load/store request per valid/ready handshake and checks alignment.
//  Builds byte-lane write mask/data, pulses the memory strobes for exactly one cycle,
//  models SRAM latency and holds the result until writeback accepts it.
//  Keeps memory DPI accesses to one per instruction.
// PARAMETERS
//  LAT   1   cycles from ISSUE cycle to out_valid (legal 1..15)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous, active-low reset
//  in_valid    in   1         EXU request valid
//  in_ready    out  1         LSU can accept (state==IDLE)
//  in_is_load  in   1         request is a load
//  in_is_store in   1         request is a store
//  in_size     in   3         `LoadB/`LoadBU/`LoadH/`LoadHU/`LoadW or `StoreB/`StoreH/`StoreW
//  in_addr     in   `RegBus   byte address
//  in_wdata    in   `RegBus   store data, right-aligned
//  out_valid   out  1         response valid to WBU
//  out_ready   in   1         WBU accepts response
//  out_rdata   out  `RegBus   extended load data (0 for stores/errors)
//  out_err     out  1         misaligned or illegal request, no memory access done
//  mem_wen     out  1         to memory: write strobe
//  wmask       out  8         byte mask; [3:0] = lanes, [7:4] always 0
//  waddr       out  `RegBus   write address, word aligned ({addr[31:2],2'b00})
//  wdata       out  `RegBus   lane-shifted store data (in_wdata << 8*addr[1:0])
//  mem_ren     out  1         to memory: read strobe
//  rmask       out  3         load size passed to memory (captured in_size)
//  raddr       out  `RegBus   read address, unmodified byte address
//  rdata       in   `RegBus   extended read data from memory (combinational)
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Error path: IDLE -> RESP.
//  - IDLE: in_ready=1. On in_valid, capture addr/size/wdata/kind into regs.
//    Next state is ISSUE, or RESP if an error is detected.
//  - Error: misaligned H/HU/StoreH with addr[0]=1; W/StoreW with addr[1:0]!=0;
//    load and store both set. Result: out_err=1, out_rdata=0, no strobe.
//  - No-op: neither load nor store -> RESP with out_err=0, out_rdata=0, no strobe.
//  - ISSUE: exactly one cycle. Assert mem_ren or mem_wen from registered state,
//    never from inputs.
//  - Store ISSUE: wmask = {4'b0, lanes << addr[1:0]}, lanes = B:0001, H:0011, W:1111.
//  - Load ISSUE: rmask = size; rdata captured into result reg on the ISSUE->WAIT edge.
//  - All mem_* outputs are 0 outside ISSUE: mask 0, addresses 0, wdata 0.
//  - WAIT: counter counts LAT-1 cycles. LAT=1 skips WAIT: ISSUE->RESP.
//  - Latency: out_valid first high LAT cycles after the ISSUE cycle;
//    accept edge to out_valid = LAT+1 cycles.
//  - RESP: out_valid=1. out_rdata/out_err stay stable until out_valid&&out_ready,
//    then IDLE. New request accepted no earlier than the cycle after RESP ends
//    (no bypass).
//  - Stores also return a response, so writeback stays in order.
//  - Reset, any time including mid-ISSUE: asynchronously to IDLE.
//    out_valid=0, out_rdata=0, out_err=0, counter=0, all strobes/masks/addresses 0.
//    in_ready=1 while reset is held; any in-flight request is dropped.
// STRUCTURE
//  - defines.v: add `StoreB 3'b000, `StoreH 3'b001, `StoreW 3'b010.
//    Reuse `Load* and `RegBus.
//  - FSM state encoding is local to lsu (localparam).
//  - One sub-module: lsu_align. Combinational; from size + addr[1:0] + store data
//    it produces lane mask, shifted wdata and misalign flag.
// TESTING
//  - SW 0xDEADBEEF @0x80000004, LAT=1: one-cycle mem_wen, wmask=0x0F,
//    waddr=0x80000004; out_valid 2 cycles after accept, err=0.
//  - SB 0x000000AB @0x80000003: wmask=0x08, wdata=0xAB000000;
//    LW back from 0x80000000 returns 0xAB..byte in [31:24].
//  - LH @0x80000001: no strobe ever, out_err=1, out_rdata=0, RESP next cycle.
//  - LAT=4, LB of byte 0x80 (memory returns 0xFFFFFF80): out_rdata=0xFFFFFF80
//    exactly 5 cycles after accept; mem_ren high exactly 1 cycle.
//  - out_ready held low 3 cycles in RESP: out_valid/out_rdata stable, in_ready=0;
//    accept resumes only after the handshake.
//  - rst low during ISSUE of a SW: mem_wen falls without a clock edge.
//    After release in_ready=1, out_valid=0, no response for the dropped op.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared widths, access-size encodings and request legality helper for the
// load/store unit.
package lsu_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 4;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;

  localparam logic [2:0] STORE_B = 3'b000;
  localparam logic [2:0] STORE_H = 3'b001;
  localparam logic [2:0] STORE_W = 3'b010;

  function automatic logic size_legal(input logic is_store, input logic [2:0] size);
    if (is_store) begin
      return (size == STORE_B) || (size == STORE_H) || (size == STORE_W);
    end else begin
      return (size == LOAD_B) || (size == LOAD_H) || (size == LOAD_W) ||
             (size == LOAD_BU) || (size == LOAD_HU);
    end
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: lane mask, lane-shifted store data and misalignment
// flag from the access size and the low address bits.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       size_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [REG_W-1:0] wdata_i,
  output logic [3:0]       lanes_o,
  output logic [REG_W-1:0] wdata_o,
  output logic             misalign_o
);

  always_comb begin
    lanes_o    = 4'b0000;
    misalign_o = 1'b0;
    case (size_i[1:0])
      2'b00: lanes_o = 4'b0001 << addr_lo_i;
      2'b01: begin
        lanes_o    = 4'b0011 << addr_lo_i;
        misalign_o = addr_lo_i[0];
      end
      2'b10: begin
        lanes_o    = 4'b1111;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: begin
        lanes_o    = 4'b0000;
        misalign_o = 1'b0;
      end
    endcase
  end

  assign wdata_o = wdata_i << {addr_lo_i, 3'b000};

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request per handshake, one-cycle memory strobe from
// registered state, LAT-cycle SRAM latency, response held until writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic [2:0]       in_size,
  input  logic [REG_W-1:0] in_addr,
  input  logic [REG_W-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rdata,
  output logic             out_err,
  output logic             mem_wen,
  output logic [7:0]       wmask,
  output logic [REG_W-1:0] waddr,
  output logic [REG_W-1:0] wdata,
  output logic             mem_ren,
  output logic [2:0]       rmask,
  output logic [REG_W-1:0] raddr,
  input  logic [REG_W-1:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LAT > 1) ? LAT - 2 : 0);

  state_e           state_q;
  logic             out_valid_q, out_err_q, mem_wen_q, mem_ren_q;
  logic [REG_W-1:0] out_rdata_q, waddr_q, wdata_q, raddr_q;
  logic [3:0]       wmask_q;
  logic [2:0]       rmask_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       lanes_s;
  logic [REG_W-1:0] wdata_sh_s;
  logic             misalign_s, noop_s, bad_s;

  lsu_align u_align (
    .size_i    (in_size),
    .addr_lo_i (in_addr[1:0]),
    .wdata_i   (in_wdata),
    .lanes_o   (lanes_s),
    .wdata_o   (wdata_sh_s),
    .misalign_o(misalign_s)
  );

  assign noop_s = !in_is_load && !in_is_store;
  assign bad_s  = (in_is_load && in_is_store) ||
                  (!noop_s && (misalign_s || !size_legal(in_is_store, in_size)));

  // Request FSM; memory-side registers are non-zero only while in ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      wmask_q     <= 4'b0000;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rmask_q     <= 3'b000;
      raddr_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            out_rdata_q <= '0;
            out_err_q   <= bad_s;
            cnt_q       <= '0;
            if (bad_s || noop_s) begin
              state_q     <= S_RESP;
              out_valid_q <= 1'b1;
            end else begin
              state_q   <= S_ISSUE;
              mem_wen_q <= in_is_store;
              mem_ren_q <= in_is_load;
              if (in_is_store) begin
                wmask_q <= lanes_s;
                waddr_q <= {in_addr[REG_W-1:2], 2'b00};
                wdata_q <= wdata_sh_s;
              end else begin
                rmask_q <= in_size;
                raddr_q <= in_addr;
              end
            end
          end
        end
        S_ISSUE: begin
          mem_wen_q <= 1'b0;
          mem_ren_q <= 1'b0;
          wmask_q   <= 4'b0000;
          waddr_q   <= '0;
          wdata_q   <= '0;
          rmask_q   <= 3'b000;
          raddr_q   <= '0;
          if (mem_ren_q) begin
            out_rdata_q <= rdata;
          end
          if (LAT == 1) begin
            state_q     <= S_RESP;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q     <= S_RESP;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_RESP: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;
  assign mem_wen   = mem_wen_q;
  assign wmask     = {4'b0000, wmask_q};
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign mem_ren   = mem_ren_q;
  assign rmask     = rmask_q;
  assign raddr     = raddr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu at LAT=1 and LAT=4, each with its own byte-lane
// memory and a byte-array reference model.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          strobe;
    logic [7:0]  wmask;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [2:0]  rmask;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input int lat, input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL L%0d %s: got 0x%0h, want 0x%0h", lat, name, act, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_h
    localparam int L = (g == 0) ? 1 : 4;

    logic        rst, in_valid, in_ready, in_is_load, in_is_store;
    logic        out_valid, out_ready, out_err, mem_wen, mem_ren;
    logic [2:0]  in_size, rmask;
    logic [31:0] in_addr, in_wdata, out_rdata, waddr, wdata, raddr, rdata, dev_sh;
    logic [7:0]  wmask;
    logic [31:0] dev_mem [0:15];
    logic [7:0]  byte_mem [0:63];
    exp_t        sb [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          hold_req = 0;
    bit          done = 1'b0;

    lsu #(.LAT(L)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
      .in_is_store(in_is_store), .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
      .mem_wen(mem_wen), .wmask(wmask), .waddr(waddr), .wdata(wdata),
      .mem_ren(mem_ren), .rmask(rmask), .raddr(raddr), .rdata(rdata)
    );

    function automatic logic [7:0] init_byte(input int k);
      return 8'((k * 73 + 11) ^ (L * 29));
    endfunction

    // Data memory: word array with byte-lane writes, combinational extended read.
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int w = 0; w < 16; w++)
          dev_mem[w] <= {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
      end else if (mem_wen) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) dev_mem[waddr[5:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end

    always_comb begin
      dev_sh = dev_mem[raddr[5:2]] >> {raddr[1:0], 3'b000};
      case (rmask)
        3'b000:  rdata = {{24{dev_sh[7]}}, dev_sh[7:0]};
        3'b100:  rdata = {24'h0, dev_sh[7:0]};
        3'b001:  rdata = {{16{dev_sh[15]}}, dev_sh[15:0]};
        3'b101:  rdata = {16'h0, dev_sh[15:0]};
        default: rdata = dev_sh;
      endcase
    end

    // Reference model: byte-addressed memory, applied in program order.
    function automatic void model(input logic ld, input logic st, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd, output exp_t e);
      int nb, off;
      logic legal;
      longint v;
      e.err = 1'b0; e.rdata = 32'h0; e.strobe = 0; e.wmask = 8'h0; e.waddr = 32'h0;
      e.wdata = 32'h0; e.raddr = 32'h0; e.rmask = 3'h0; e.lat = 1; e.acc = 0;
      nb = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      off = int'(a[5:0]);
      legal = st ? (sz <= 3'd2) : (sz <= 3'd2 || sz == 3'd4 || sz == 3'd5);
      if (ld && st) begin
        e.err = 1'b1;
      end else if (ld || st) begin
        if (!legal || (off % nb) != 0) begin
          e.err = 1'b1;
        end else if (st) begin
          e.lat = L + 1; e.strobe = 2;
          e.waddr = a & 32'hFFFF_FFFC;
          e.wmask = 8'(((1 << nb) - 1) << (off % 4));
          e.wdata = wd << (8 * (off % 4));
          for (int i = 0; i < nb; i++) byte_mem[off + i] = wd[8*i +: 8];
        end else begin
          e.lat = L + 1; e.strobe = 1; e.raddr = a; e.rmask = sz; v = 0;
          for (int i = 0; i < nb; i++) v += longint'(byte_mem[off + i]) << (8 * i);
          if (!sz[2] && v[8*nb-1]) v -= (longint'(1) << (8 * nb));
          e.rdata = v[31:0];
        end
      end
    endfunction

    task automatic issue(input logic ld, input logic st, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
      exp_t e;
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_size = sz; in_addr = a; in_wdata = wd;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check(L, "accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
      end else begin
        model(ld, st, sz, a, wd, e);
        e.acc = cyc;
        sb[wr_idx % 1024] = e;
        wr_idx++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold_req = hold;
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (rd_idx != wr_idx && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (rd_idx != wr_idx) check(L, "drain_timeout", 32'(wr_idx - rd_idx), 32'd0);
    endtask

    initial begin : drv
      int k;
      logic [2:0] sz;
      logic [31:0] a;
      rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
      in_size = 3'b000; in_addr = 32'h0; in_wdata = 32'h0;
      for (int i = 0; i < 64; i++) byte_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      check(L, "rst_in_ready", 32'(in_ready), 32'd1);
      check(L, "rst_out_valid", 32'(out_valid), 32'd0);
      check(L, "rst_out_err", 32'(out_err), 32'd0);
      check(L, "rst_out_rdata", out_rdata, 32'd0);
      check(L, "rst_strobes", 32'({mem_wen, mem_ren}), 32'd0);
      check(L, "rst_bus", 32'(|{wmask, rmask, waddr, wdata, raddr}), 32'd0);
      #2 rst = 1'b1;

      issue(1'b0, 1'b1, STORE_W, 32'h8000_0004, 32'hDEAD_BEEF, 0);
      issue(1'b0, 1'b1, STORE_B, 32'h8000_0003, 32'h0000_00AB, 0);
      issue(1'b1, 1'b0, LOAD_W,  32'h8000_0000, 32'h0, 0);
      issue(1'b1, 1'b0, LOAD_H,  32'h8000_0001, 32'h0, 0);
      issue(1'b0, 1'b1, STORE_B, 32'h8000_0010, 32'h0000_0080, 0);
      issue(1'b1, 1'b0, LOAD_B,  32'h8000_0010, 32'h0, 0);
      issue(1'b1, 1'b0, LOAD_BU, 32'h8000_0010, 32'h0, 3);
      issue(1'b1, 1'b0, LOAD_W,  32'h8000_0004, 32'h0, 3);
      issue(1'b0, 1'b1, STORE_H, 32'h8000_0006, 32'h1234_8765, 0);
      issue(1'b1, 1'b0, LOAD_HU, 32'h8000_0006, 32'h0, 0);
      issue(1'b1, 1'b1, LOAD_W,  32'h8000_0008, 32'h0, 0);
      issue(1'b0, 1'b0, LOAD_W,  32'h8000_0009, 32'h0, 0);
      issue(1'b1, 1'b0, 3'b011,  32'h8000_0008, 32'h0, 0);
      issue(1'b0, 1'b1, STORE_W, 32'h8000_000A, 32'h5555_AAAA, 0);
      drain();

      // Reset while a store is in ISSUE: strobe must drop with no clock edge.
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_size = STORE_W;
      in_addr = 32'h8000_0020; in_wdata = 32'h1122_3344;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check(L, "issue_wen", 32'(mem_wen), 32'd1);
      rst = 1'b0;
      #1;
      check(L, "rst_wen_drop", 32'(mem_wen), 32'd0);
      check(L, "rst_wmask_drop", 32'(wmask), 32'd0);
      check(L, "rst_waddr_drop", waddr, 32'd0);
      check(L, "rst_mid_in_ready", 32'(in_ready), 32'd1);
      check(L, "rst_mid_out_valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      issue(1'b1, 1'b0, LOAD_W, 32'h8000_0020, 32'h0, 0);

      for (int i = 0; i < 150; i++) begin
        k  = $urandom_range(0, 9);
        sz = 3'($urandom_range(0, 7));
        a  = 32'h8000_0000 | 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz[1:0]) - 32'd1);
        issue(k == 0 || k >= 6, k == 0 || (k >= 2 && k <= 5), sz, a, $urandom, (k == 7) ? 2 : 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      done = 1'b1;
    end

    initial begin : mon
      exp_t e;
      int scnt, hold_left;
      bit active;
      scnt = 0; hold_left = 0; active = 1'b0; out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          scnt = 0; active = 1'b0; out_ready = 1'b0;
        end else begin
          if (mem_wen || mem_ren) begin
            if (rd_idx == wr_idx) begin
              check(L, "strobe_without_request", 32'd0, 32'd1);
            end else begin
              e = sb[rd_idx % 1024];
              scnt++;
              check(L, "strobe_kind", 32'({mem_wen, mem_ren}), 32'(e.strobe));
              check(L, "wmask", 32'(wmask), 32'(e.wmask));
              check(L, "waddr", waddr, e.waddr);
              check(L, "wdata", wdata, e.wdata);
              check(L, "raddr", raddr, e.raddr);
              check(L, "rmask", 32'(rmask), 32'(e.rmask));
            end
          end else begin
            check(L, "idle_bus", 32'(|{wmask, waddr, wdata, raddr, rmask}), 32'd0);
          end
          if (out_valid) begin
            if (rd_idx == wr_idx) begin
              check(L, "response_without_request", 32'd0, 32'd1);
              out_ready = 1'b1;
            end else begin
              e = sb[rd_idx % 1024];
              if (!active) begin
                active = 1'b1;
                hold_left = hold_req;
                check(L, "latency", 32'(cyc - e.acc), 32'(e.lat));
                check(L, "strobe_cycles", 32'(scnt), (e.strobe != 0) ? 32'd1 : 32'd0);
              end
              check(L, "out_rdata", out_rdata, e.rdata);
              check(L, "out_err", 32'(out_err), 32'(e.err));
              check(L, "in_ready_in_resp", 32'(in_ready), 32'd0);
              if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
              end else begin
                out_ready = ($urandom_range(0, 3) != 0);
              end
              if (out_ready) begin
                rd_idx++;
                active = 1'b0;
                scnt = 0;
              end
            end
          end else begin
            out_ready = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 30000; t++) begin
      @(posedge clk);
      if (gen_h[0].done && gen_h[1].done) break;
    end
    if (!(gen_h[0].done && gen_h[1].done)) check(0, "run_timeout", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
